// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the MMIO UART transmitter.
// The CPU/wrapper side drives address and strobes; the UART answers with read data and hit.
interface mmio_uart_tx_if;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        hit;

  modport master (
    output addr, wr_data, wr_en, rd_en,
    input  rd_data, hit
  );

  modport slave (
    input  addr, wr_data, wr_en, rd_en,
    output rd_data, hit
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO fed by stores, 8N1 LSB-first serialiser, status word.
// Optional even-parity frame (8E1) when MMIO_UART_TX_PARITY_EN is defined.
module mmio_uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [31:0] TX_ADDR     = 32'hFFFFFFF8,
  parameter logic [31:0] STATUS_ADDR = 32'hFFFFFFF4
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int unsigned DIV      = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DCW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0] RELOAD   = DCW'(DIV - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  if (DIV < 2) begin : g_div_check
    $error("mmio_uart_tx: baud divisor must be at least 2");
  end

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("mmio_uart_tx: FIFO_DEPTH must be a power of two in 2..256");
  end

`ifdef MMIO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t         state, state_n;
  logic [DCW-1:0] cnt, cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic           tx_n;
  logic           pop, load, shift_en;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           overflow;
  logic [7:0]     shift;
`ifdef MMIO_UART_TX_PARITY_EN
  logic           parity;
`endif

  logic tx_sel, st_sel, empty, full;
  logic push_req, push, drop, ovf_clr;
  logic [31:0] status;

  assign tx_sel   = (bus.addr == TX_ADDR);
  assign st_sel   = (bus.addr == STATUS_ADDR);
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign push_req = bus.wr_en && tx_sel;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign ovf_clr  = bus.rd_en && st_sel;
  assign busy     = !empty || (state != IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    tx_n      = 1'b1;
    pop       = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          cnt_n   = RELOAD;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (cnt == '0) begin
          state_n   = DATA;
          cnt_n     = RELOAD;
          bit_idx_n = 3'd0;
          tx_n      = shift[0];
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (cnt == '0) begin
          cnt_n    = RELOAD;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = parity;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shift[1];
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef MMIO_UART_TX_PARITY_EN
      PARITY: begin
        tx_n = parity;
        if (cnt == '0) begin
          state_n = STOP;
          cnt_n   = RELOAD;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (cnt == '0) begin
          // Chain straight into the next start bit when more data is queued
          if (!empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            cnt_n   = RELOAD;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data[7:0];
    if (load) shift <= mem[rd_ptr];
    else if (shift_en) shift <= {1'b0, shift[7:1]};
`ifdef MMIO_UART_TX_PARITY_EN
    if (load) parity <= ^mem[rd_ptr];
`endif
  end

  always_comb begin
    status         = '0;
    status[0]      = empty;
    status[1]      = full;
    status[2]      = busy;
    status[3]      = overflow;
    status[3+CW:4] = count;
`ifdef MMIO_UART_TX_PARITY_EN
    status[31]     = 1'b1;
`endif
  end

  assign bus.rd_data = st_sel ? status : 32'h0;
  assign bus.hit     = tx_sel || st_sel;

endmodule
